// File: rtl/iterative_mul_pool_pkg.sv
// Shared types and helpers for the iterative multiplier pool.
package iterative_mul_pool_pkg;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_BUSY = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_e;

    // Modular age test: a is younger than b when (a-b) mod 2^sn lies in
    // [1, 2^(sn-1)-1]. Equal sequence numbers are never younger.
    function automatic logic younger(input logic [31:0] a, input logic [31:0] b, input int sn);
        logic [31:0] w_mask;
        logic [31:0] w_diff;
        logic [31:0] w_half;
        w_mask = (sn >= 32) ? 32'hFFFF_FFFF : ((32'd1 << sn) - 32'd1);
        w_diff = (a - b) & w_mask;
        w_half = 32'd1 << (sn - 1);
        return (w_diff != 32'd0) && (w_diff < w_half);
    endfunction

endpackage

// File: rtl/iterative_mul_pool_lane.sv
// One iterative shift-add multiplier lane: FSM, cycle counter, datapath and
// the metadata of the op it carries.
module iterative_mul_lane
    import iterative_mul_pool_pkg::*;
#(
    parameter int P_NUM_CYCLES     = 16,
    parameter int P_SEQ_NUM_BITS   = 5,
    parameter int P_PHYS_ADDR_BITS = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_issue,
    input  logic                        i_kill,
    input  logic                        i_retire,
    input  logic [31:0]                 i_pc,
    input  logic [31:0]                 i_op1,
    input  logic [31:0]                 i_op2,
    input  logic [P_SEQ_NUM_BITS-1:0]   i_seq,
    input  logic [4:0]                  i_waddr,
    input  logic [P_PHYS_ADDR_BITS-1:0] i_preg,
    output lane_state_e                 o_state,
    output logic [31:0]                 o_pc,
    output logic [P_SEQ_NUM_BITS-1:0]   o_seq,
    output logic [4:0]                  o_waddr,
    output logic [P_PHYS_ADDR_BITS-1:0] o_preg,
    output logic [31:0]                 o_result
);

    localparam int BITS = 32 / P_NUM_CYCLES;
    localparam int CW   = (P_NUM_CYCLES > 1) ? $clog2(P_NUM_CYCLES) : 1;

    lane_state_e                 r_state;
    logic [CW-1:0]               r_cnt;
    logic [31:0]                 r_mcand;
    logic [31:0]                 r_mplier;
    logic [31:0]                 r_acc;
    logic [31:0]                 r_pc;
    logic [P_SEQ_NUM_BITS-1:0]   r_seq;
    logic [4:0]                  r_waddr;
    logic [P_PHYS_ADDR_BITS-1:0] r_preg;
    logic [31:0]                 w_partial;

    // Partial product of this step's BITS multiplier digits, truncated to 32 bits.
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < BITS; j++) begin
            if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
        end
    end

    // Lane FSM plus datapath; a squash hit overrides everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= LANE_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_pc     <= '0;
            r_seq    <= '0;
            r_waddr  <= '0;
            r_preg   <= '0;
        end else if (i_kill) begin
            r_state <= LANE_IDLE;
        end else begin
            case (r_state)
                LANE_IDLE: if (i_issue) begin
                    r_state  <= LANE_BUSY;
                    r_cnt    <= CW'(P_NUM_CYCLES - 1);
                    r_mcand  <= i_op1;
                    r_mplier <= i_op2;
                    r_acc    <= '0;
                    r_pc     <= i_pc;
                    r_seq    <= i_seq;
                    r_waddr  <= i_waddr;
                    r_preg   <= i_preg;
                end
                LANE_BUSY: begin
                    r_acc    <= r_acc + w_partial;
                    r_mcand  <= r_mcand << BITS;
                    r_mplier <= r_mplier >> BITS;
                    if (r_cnt == '0) r_state <= LANE_DONE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                LANE_DONE: if (i_retire) r_state <= LANE_IDLE;
                default:   r_state <= LANE_IDLE;
            endcase
        end
    end

    assign o_state  = r_state;
    assign o_pc     = r_pc;
    assign o_seq    = r_seq;
    assign o_waddr  = r_waddr;
    assign o_preg   = r_preg;
    assign o_result = r_acc;

endmodule

// File: rtl/iterative_mul_pool.sv
// Pool of iterative multiplier lanes behind one issue port and one writeback
// port: lowest-free dispatch, squash masking, round-robin writeback.
module iterative_mul_pool
    import iterative_mul_pool_pkg::*;
#(
    parameter int p_num_lanes      = 2,
    parameter int p_num_cycles     = 16,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        d_val,
    output logic                        d_rdy,
    input  logic [31:0]                 d_pc,
    input  logic [31:0]                 d_op1,
    input  logic [31:0]                 d_op2,
    input  logic [p_seq_num_bits-1:0]   d_seq_num,
    input  logic [4:0]                  d_waddr,
    input  logic [p_phys_addr_bits-1:0] d_preg,
    output logic                        w_val,
    input  logic                        w_rdy,
    output logic [31:0]                 w_pc,
    output logic [p_seq_num_bits-1:0]   w_seq_num,
    output logic [4:0]                  w_waddr,
    output logic [p_phys_addr_bits-1:0] w_preg,
    output logic [31:0]                 w_wdata,
    output logic                        w_wen,
    input  logic                        squash_val,
    input  logic [p_seq_num_bits-1:0]   squash_seq
);

    localparam int LW = (p_num_lanes > 1) ? $clog2(p_num_lanes) : 1;

    lane_state_e                 w_state    [p_num_lanes];
    logic [31:0]                 w_lane_pc  [p_num_lanes];
    logic [p_seq_num_bits-1:0]   w_lane_seq [p_num_lanes];
    logic [4:0]                  w_lane_wa  [p_num_lanes];
    logic [p_phys_addr_bits-1:0] w_lane_pr  [p_num_lanes];
    logic [31:0]                 w_lane_res [p_num_lanes];

    logic [p_num_lanes-1:0] w_kill;
    logic [p_num_lanes-1:0] w_done_ok;
    logic                   w_any_idle;
    logic [LW-1:0]          w_free_idx;
    logic                   w_gnt_val;
    logic [LW-1:0]          w_gnt_idx;
    logic                   w_issue_drop;
    logic                   w_fire;
    logic [LW-1:0]          r_rr;
    logic                   r_live;

    // d_rdy is held low during reset and for the edge that releases it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_live <= 1'b0;
        else      r_live <= 1'b1;
    end

    // Squash hits and the arbitration mask that hides squashed lanes this cycle.
    always_comb begin
        w_kill    = '0;
        w_done_ok = '0;
        for (int i = 0; i < p_num_lanes; i++) begin
            w_kill[i]    = squash_val && (w_state[i] != LANE_IDLE) &&
                           younger(32'(w_lane_seq[i]), 32'(squash_seq), p_seq_num_bits);
            w_done_ok[i] = (w_state[i] == LANE_DONE) && !w_kill[i];
        end
    end

    // Lowest-index IDLE lane takes the next issue.
    always_comb begin
        w_any_idle = 1'b0;
        w_free_idx = '0;
        for (int i = p_num_lanes - 1; i >= 0; i--) begin
            if (w_state[i] == LANE_IDLE) begin
                w_any_idle = 1'b1;
                w_free_idx = LW'(i);
            end
        end
    end

    assign d_rdy        = r_live && w_any_idle;
    assign w_issue_drop = squash_val && younger(32'(d_seq_num), 32'(squash_seq), p_seq_num_bits);
    assign w_fire       = d_val && d_rdy && !w_issue_drop;

    // Round-robin pick: the first unmasked DONE lane at or after r_rr wins.
    always_comb begin
        w_gnt_val = 1'b0;
        w_gnt_idx = '0;
        for (int k = p_num_lanes - 1; k >= 0; k--) begin
            if (w_done_ok[(int'(r_rr) + k) % p_num_lanes]) begin
                w_gnt_val = 1'b1;
                w_gnt_idx = LW'((int'(r_rr) + k) % p_num_lanes);
            end
        end
    end

    // Pointer moves past the lane that just retired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_rr <= '0;
        else if (w_gnt_val && w_rdy)
            r_rr <= (w_gnt_idx == LW'(p_num_lanes - 1)) ? '0 : w_gnt_idx + 1'b1;
    end

    assign w_val     = w_gnt_val;
    assign w_pc      = w_lane_pc[w_gnt_idx];
    assign w_seq_num = w_lane_seq[w_gnt_idx];
    assign w_waddr   = w_lane_wa[w_gnt_idx];
    assign w_preg    = w_lane_pr[w_gnt_idx];
    assign w_wdata   = w_lane_res[w_gnt_idx];
    assign w_wen     = (w_waddr != 5'd0);

    for (genvar g = 0; g < p_num_lanes; g++) begin : g_lane
        iterative_mul_lane #(
            .P_NUM_CYCLES    (p_num_cycles),
            .P_SEQ_NUM_BITS  (p_seq_num_bits),
            .P_PHYS_ADDR_BITS(p_phys_addr_bits)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_issue (w_fire && (w_free_idx == LW'(g))),
            .i_kill  (w_kill[g]),
            .i_retire(w_rdy && w_gnt_val && (w_gnt_idx == LW'(g))),
            .i_pc    (d_pc),
            .i_op1   (d_op1),
            .i_op2   (d_op2),
            .i_seq   (d_seq_num),
            .i_waddr (d_waddr),
            .i_preg  (d_preg),
            .o_state (w_state[g]),
            .o_pc    (w_lane_pc[g]),
            .o_seq   (w_lane_seq[g]),
            .o_waddr (w_lane_wa[g]),
            .o_preg  (w_lane_pr[g]),
            .o_result(w_lane_res[g])
        );
    end

endmodule
